hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
- Hazard sequencer for the 5-stage pipelined MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects RAW hazards between the instruction in ID and older instructions in EX/MEM/WB; freezes PC and IF/ID and injects ID/EX bubbles for the required number of cycles.
- Flushes younger stages when a branch, jump or jr redirect resolves in MEM.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_WIDTH, 16, width of stall_count_o and flush_count_o.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs_i  in  5  rs field of the instruction in ID (ID_instr[25:21]).
- id_rt_i  in  5  rt field of the instruction in ID (ID_instr[20:16]).
- id_uses_rs_i  in  1  ID instruction reads rs.
- id_uses_rt_i  in  1  ID instruction reads rt.
- ex_rs_i  in  5  rs field of the instruction in EX.
- ex_rt_i  in  5  rt field of the instruction in EX.
- ex_reg_write_i  in  1  EX instruction writes a register.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_write_reg_i  in  5  destination register of the EX instruction.
- mem_reg_write_i  in  1  MEM instruction writes a register.
- mem_write_reg_i  in  5  destination register of the MEM instruction.
- wb_reg_write_i  in  1  WB instruction writes a register.
- wb_write_reg_i  in  5  destination register of the WB instruction.
- mem_redirect_i  in  1  taken beq/bne, jump or jr resolved in MEM this cycle.
- pc_write_o  out  1  PC load enable.
- if_id_write_o  out  1  IF/ID load enable.
- id_ex_bubble_o  out  1  zero the ID/EX control fields.
- if_id_flush_o  out  1  clear IF/ID.
- id_ex_flush_o  out  1  clear ID/EX.
- ex_mem_flush_o  out  1  clear EX/MEM.
- forward_a_o  out  2  ALU operand A source: 00 regfile, 10 EX/MEM result, 01 WB data.
- forward_b_o  out  2  ALU operand B source, same encoding.
- stalling_o  out  1  state == STALL.
- stall_count_o  out  CNT_WIDTH  number of stall cycles.
- flush_count_o  out  CNT_WIDTH  number of redirect events.

Behaviour:
- Reset (synchronous, active-high):
  - state = RUN, remaining-stall counter = 0, both event counters = 0.
  - pc_write_o = 1, if_id_write_o = 1; all flush and bubble outputs = 0; forward outputs = 00.
  - reset has priority over everything, including mid-stall and a coincident redirect.
- Match rule: source register X matches stage S when:
  - the uses bit for X is set,
  - X != 0,
  - S reg_write is set,
  - S dest == X.
- Required stall length N (no forwarding build):
  - match in EX -> N = 3; in MEM -> N = 2; in WB -> N = 1 (regfile writes at the clock edge; ID reads combinationally).
  - The youngest matching stage sets N (EX over MEM over WB).
- States: RUN and STALL.
  - RUN, hazard detected, no redirect:
    - stall outputs asserted combinationally the same cycle: pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1.
    - counter loaded with N-1.
    - next state = STALL if N-1 > 0, else RUN.
  - STALL: stall outputs held asserted; hazard inputs are ignored; counter decrements each cycle; at 1 -> 0, return to RUN.
  - A stall therefore lasts exactly N cycles, including the detection cycle.
- Redirect:
  - mem_redirect_i = 1 asserts if_id_flush_o, id_ex_flush_o and ex_mem_flush_o the same cycle (combinational).
  - Forces pc_write_o = 1, if_id_write_o = 1 and id_ex_bubble_o = 0, so the redirect PC loads.
  - Next state = RUN, counter cleared.
  - Redirect overrides a new or in-progress stall.
- Counters:
  - stall_count_o increments on every cycle with id_ex_bubble_o = 1.
  - flush_count_o increments on every cycle with mem_redirect_i = 1.
  - Both saturate at all-ones.
- Output timing: all control outputs are combinational from state and inputs; the counter outputs are registered.

Optional Feature:
- FORWARDING_EN defined:
  - forward_a_o / forward_b_o are driven from ex_rs_i / ex_rt_i.
  - 10 when mem_reg_write_i, mem dest != 0 and mem dest matches.
  - Otherwise 01 when the same conditions hold for WB.
  - MEM has priority over WB.
  - The only stall is load-use: ex_mem_read_i and an EX match -> N = 1. MEM and WB matches cause no stall.
- FORWARDING_EN undefined:
  - forward outputs are tied to 00.
  - Full N = 3/2/1 stall rules apply.

Test Plan:
- No forwarding; EX add writes $8; ID reads rs = $8 -> pc_write_o = 0 for exactly 3 cycles, stalling_o high for cycles 2-3, stall_count_o = 3.
- No forwarding; WB writes $9; ID reads rt = $9 -> 1-cycle stall, stalling_o never asserted.
- EX writes $0; ID reads $0 -> no stall, pc_write_o stays 1.
- mem_redirect_i asserted in cycle 2 of a 3-cycle stall -> all three flushes = 1 that cycle, pc_write_o = 1, state RUN next cycle, flush_count_o = 1, stall_count_o = 1.
- FORWARDING_EN; MEM and WB both write $5; ex_rs_i = 5 -> forward_a_o = 10. Load in EX to $5 with ID rt = $5 -> exactly 1 bubble.
- Reset asserted mid-stall -> next cycle: state RUN, pc_write_o = 1, both counters = 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// RAW hazard sequencer for the 5-stage MIPS pipeline: stall/bubble control, redirect flushes,
// operand forwarding select and saturating event counters. Define FORWARDING_EN for the forwarding build.
module hazard_control_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs_i,
    input  logic [4:0]           id_rt_i,
    input  logic                 id_uses_rs_i,
    input  logic                 id_uses_rt_i,
    input  logic [4:0]           ex_rs_i,
    input  logic [4:0]           ex_rt_i,
    input  logic                 ex_reg_write_i,
    input  logic                 ex_mem_read_i,
    input  logic [4:0]           ex_write_reg_i,
    input  logic                 mem_reg_write_i,
    input  logic [4:0]           mem_write_reg_i,
    input  logic                 wb_reg_write_i,
    input  logic [4:0]           wb_write_reg_i,
    input  logic                 mem_redirect_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 id_ex_bubble_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_flush_o,
    output logic [1:0]           forward_a_o,
    output logic [1:0]           forward_b_o,
    output logic                 stalling_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    typedef enum logic {RUN, STALL} state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             remain_reg, remain_next;
    logic [CNT_WIDTH-1:0]   stall_count_reg, flush_count_reg;
    logic [1:0]             need;
    logic                   ex_hit;
    logic                   stall_now;
    logic [1:0]             fwd_a, fwd_b;

    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic we, input logic [4:0] dest);
        return uses && (src != 5'd0) && we && (dest == src);
    endfunction

    assign ex_hit = src_match(id_uses_rs_i, id_rs_i, ex_reg_write_i, ex_write_reg_i) |
                    src_match(id_uses_rt_i, id_rt_i, ex_reg_write_i, ex_write_reg_i);

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (src_match(1'b1, src, mem_reg_write_i, mem_write_reg_i))
            return 2'b10;
        else if (src_match(1'b1, src, wb_reg_write_i, wb_write_reg_i))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Only a load result cannot be bypassed in time: one bubble covers load-use.
    assign need  = (ex_hit && ex_mem_read_i) ? 2'd1 : 2'd0;
    assign fwd_a = fwd_sel(ex_rs_i);
    assign fwd_b = fwd_sel(ex_rt_i);
`else
    logic mem_hit, wb_hit;
    logic unused_fwd_inputs;

    assign mem_hit = src_match(id_uses_rs_i, id_rs_i, mem_reg_write_i, mem_write_reg_i) |
                     src_match(id_uses_rt_i, id_rt_i, mem_reg_write_i, mem_write_reg_i);
    assign wb_hit  = src_match(id_uses_rs_i, id_rs_i, wb_reg_write_i, wb_write_reg_i) |
                     src_match(id_uses_rt_i, id_rt_i, wb_reg_write_i, wb_write_reg_i);
    // Youngest producer sets the wait; WB needs one cycle since ID reads the regfile combinationally.
    assign need  = ex_hit ? 2'd3 : (mem_hit ? 2'd2 : (wb_hit ? 2'd1 : 2'd0));
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    assign unused_fwd_inputs = ^{ex_rs_i, ex_rt_i, ex_mem_read_i};
`endif

    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        stall_now   = 1'b0;
        if (mem_redirect_i) begin
            state_next  = RUN;
            remain_next = 2'd0;
        end else if (state_reg == STALL) begin
            stall_now = 1'b1;
            if (remain_reg <= 2'd1) begin
                state_next  = RUN;
                remain_next = 2'd0;
            end else begin
                remain_next = remain_reg - 2'd1;
            end
        end else if (need != 2'd0) begin
            stall_now   = 1'b1;
            remain_next = need - 2'd1;
            state_next  = (need > 2'd1) ? STALL : RUN;
        end
    end

    assign pc_write_o     = reset | ~stall_now;
    assign if_id_write_o  = reset | ~stall_now;
    assign id_ex_bubble_o = ~reset & stall_now;
    assign if_id_flush_o  = ~reset & mem_redirect_i;
    assign id_ex_flush_o  = ~reset & mem_redirect_i;
    assign ex_mem_flush_o = ~reset & mem_redirect_i;
    assign forward_a_o    = reset ? 2'b00 : fwd_a;
    assign forward_b_o    = reset ? 2'b00 : fwd_b;
    assign stalling_o     = (state_reg == STALL);
    assign stall_count_o  = stall_count_reg;
    assign flush_count_o  = flush_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            remain_reg      <= 2'd0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
            if (stall_now && (stall_count_reg != '1))
                stall_count_reg <= stall_count_reg + 1'b1;
            if (mem_redirect_i && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

endmodule
